// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - Moore control FSM for the 16-bit multicycle accumulator datapath.
// Optional MC_ILLEGAL_TRAP_EN: illegal instructions park the FSM in HALT instead of retiring as NOP.
module multicycle_controller #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         Op,
    input  logic [8:0]         Func,
    input  logic               Zero,
    output logic               AdrSrc,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               RegWrite,
    output logic               A3Src,
    output logic               PCWrite,
    output logic               OldPCWrite,
    output logic               MDRWrite,
    output logic               ResultSrc,
    output logic               AWrite,
    output logic               BWrite,
    output logic [1:0]         ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ImmSrc,
    output logic [1:0]         PCSrc,
    output logic [2:0]         ALUControl,
    output logic               instr_done,
    output logic               halted,
    output logic [STATE_W-1:0] state_dbg
);
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMRD, S_LDWB, S_MEMWR, S_JMP, S_BRZ,
        S_CEXEC, S_CWB, S_IEXEC, S_IWB
`ifdef MC_ILLEGAL_TRAP_EN
        , S_HALT
`endif
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_IN1 = 3'b101;

    state_t     state, state_next;
    logic       c_legal, c_nop;
    logic [2:0] c_alu;

    assign state_dbg = STATE_W'(state);

    // C-type sub-op decode; Func must be exactly one of the listed one-hot codes.
    always_comb begin
        c_legal = 1'b1;
        c_nop   = 1'b0;
        c_alu   = ALU_ADD;
        case (Func)
            9'h001:  c_alu = 3'b101;
            9'h002:  c_alu = 3'b110;
            9'h004:  c_alu = 3'b000;
            9'h008:  c_alu = 3'b001;
            9'h010:  c_alu = 3'b010;
            9'h020:  c_alu = 3'b011;
            9'h040:  c_alu = 3'b100;
            9'h080:  c_nop = 1'b1;
            default: c_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_FETCH;
        else       state <= state_next;
    end

    always_comb begin
        logic illegal;
        illegal    = 1'b0;
        state_next = state;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        A3Src      = 1'b0;
        PCWrite    = 1'b0;
        OldPCWrite = 1'b0;
        MDRWrite   = 1'b0;
        ResultSrc  = 1'b0;
        AWrite     = 1'b0;
        BWrite     = 1'b0;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ImmSrc     = 2'b00;
        PCSrc      = 2'b00;
        ALUControl = ALU_ADD;
        instr_done = 1'b0;
        halted     = 1'b0;
        case (state)
            S_FETCH: begin
                IRWrite    = 1'b1;
                OldPCWrite = 1'b1;
                PCWrite    = 1'b1;
                ALUSrcB    = 2'b01;
                state_next = S_DECODE;
            end
            S_DECODE: begin
                AWrite = 1'b1;
                BWrite = 1'b1;
                case (Op)
                    4'b0000: state_next = S_MEMRD;
                    4'b0001: state_next = S_MEMWR;
                    4'b0010: state_next = S_JMP;
                    4'b0100: state_next = S_BRZ;
                    4'b1000: begin
                        if (c_nop) begin
                            state_next = S_FETCH;
                            instr_done = 1'b1;
                        end else if (c_legal) begin
                            state_next = S_CEXEC;
                        end else begin
                            illegal = 1'b1;
                        end
                    end
                    4'b1100, 4'b1101, 4'b1110, 4'b1111: state_next = S_IEXEC;
                    default: illegal = 1'b1;
                endcase
                if (illegal) begin
`ifdef MC_ILLEGAL_TRAP_EN
                    state_next = S_HALT;
`else
                    state_next = S_FETCH;
                    instr_done = 1'b1;
`endif
                end
            end
            S_MEMRD: begin
                AdrSrc     = 1'b1;
                MDRWrite   = 1'b1;
                state_next = S_LDWB;
            end
            S_LDWB: begin
                ResultSrc  = 1'b1;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                state_next = S_FETCH;
            end
            S_MEMWR: begin
                AdrSrc     = 1'b1;
                MemWrite   = 1'b1;
                instr_done = 1'b1;
                state_next = S_FETCH;
            end
            S_JMP: begin
                PCSrc      = 2'b01;
                PCWrite    = 1'b1;
                instr_done = 1'b1;
                state_next = S_FETCH;
            end
            S_BRZ: begin
                ALUSrcA    = 2'b10;
                ALUControl = ALU_IN1;
                PCSrc      = 2'b10;
                PCWrite    = Zero;
                instr_done = 1'b1;
                state_next = S_FETCH;
            end
            S_CEXEC: begin
                ALUSrcA    = 2'b10;
                ALUControl = c_alu;
                state_next = S_CWB;
            end
            S_CWB: begin
                RegWrite   = 1'b1;
                A3Src      = Func[0];
                ALUControl = c_alu;
                instr_done = 1'b1;
                state_next = S_FETCH;
            end
            S_IEXEC: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b10;
                ALUControl = {1'b0, Op[1:0]};
                state_next = S_IWB;
            end
            S_IWB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                state_next = S_FETCH;
            end
`ifdef MC_ILLEGAL_TRAP_EN
            S_HALT: begin
                halted     = 1'b1;
                state_next = S_HALT;
            end
`endif
            default: state_next = S_FETCH;
        endcase
        // Reset abandons the current instruction without letting its write land.
        if (reset) begin
            MemWrite   = 1'b0;
            IRWrite    = 1'b0;
            RegWrite   = 1'b0;
            PCWrite    = 1'b0;
            OldPCWrite = 1'b0;
            MDRWrite   = 1'b0;
            AWrite     = 1'b0;
            BWrite     = 1'b0;
        end
    end
endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - self-checking bench for multicycle_controller (either MC_ILLEGAL_TRAP_EN build).
module tb_multicycle_controller;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] Op = 4'd0;
    logic [8:0] Func = 9'd0;
    logic       Zero = 1'b0;
    logic AdrSrc, MemWrite, IRWrite, RegWrite, A3Src, PCWrite, OldPCWrite, MDRWrite;
    logic ResultSrc, AWrite, BWrite, instr_done, halted;
    logic [1:0] ALUSrcA, ALUSrcB, ImmSrc, PCSrc;
    logic [2:0] ALUControl;
    logic [3:0] state_dbg;

    multicycle_controller #(.STATE_W(4)) dut (
        .clk(clk), .reset(reset), .Op(Op), .Func(Func), .Zero(Zero),
        .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .A3Src(A3Src), .PCWrite(PCWrite), .OldPCWrite(OldPCWrite), .MDRWrite(MDRWrite),
        .ResultSrc(ResultSrc), .AWrite(AWrite), .BWrite(BWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .PCSrc(PCSrc),
        .ALUControl(ALUControl), .instr_done(instr_done), .halted(halted), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

`ifdef MC_ILLEGAL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif
    localparam logic [23:0] WE_MASK = 24'h776000;

    int checks = 0;
    int failures = 0;
    logic [23:0] exp_q[$];

    wire [23:0] obs = {AdrSrc, MemWrite, IRWrite, RegWrite, A3Src, PCWrite, OldPCWrite, MDRWrite,
                       ResultSrc, AWrite, BWrite, ALUSrcA, ALUSrcB, ImmSrc, PCSrc, ALUControl,
                       instr_done, halted};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] pk(input logic adr, mw, irw, rw, a3, pcw, opc, mdr, rs, aw, bw,
                                       input logic [1:0] sa, sb, imm, pcs, input logic [2:0] alu,
                                       input logic done, halt);
        return {adr, mw, irw, rw, a3, pcw, opc, mdr, rs, aw, bw, sa, sb, imm, pcs, alu, done, halt};
    endfunction

    function automatic bit legal_instr(input logic [3:0] op, input logic [8:0] func);
        if (op == 4'b1000) return (func[8] == 1'b0) && ($countones(func) == 1);
        return op inside {4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1100, 4'b1101, 4'b1110, 4'b1111};
    endfunction

    // Reference: the control vectors an instruction should produce, one per cycle, from FETCH on.
    task automatic model_instr(input logic [3:0] op, input logic [8:0] func, input logic zero);
        logic [2:0] c_alu_tab [7] = '{3'b101, 3'b110, 3'b000, 3'b001, 3'b010, 3'b011, 3'b100};
        logic [2:0] calu;
        bit retire_now;
        calu = 3'b000;
        for (int k = 0; k < 7; k++) if (func == (9'd1 << k)) calu = c_alu_tab[k];
        retire_now = !legal_instr(op, func) || (op == 4'b1000 && func == 9'h080);
        exp_q.push_back(pk(0,0,1,0,0,1,1,0,0,0,0, 2'b00,2'b01,2'b00,2'b00, 3'b000, 0,0));
        exp_q.push_back(pk(0,0,0,0,0,0,0,0,0,1,1, 2'b00,2'b00,2'b00,2'b00, 3'b000,
                           retire_now && (legal_instr(op, func) || !TRAP_EN), 0));
        if (!retire_now) begin
            case (op)
                4'b0000: begin
                    exp_q.push_back(pk(1,0,0,0,0,0,0,1,0,0,0, 2'b00,2'b00,2'b00,2'b00, 3'b000, 0,0));
                    exp_q.push_back(pk(0,0,0,1,0,0,0,0,1,0,0, 2'b00,2'b00,2'b00,2'b00, 3'b000, 1,0));
                end
                4'b0001: exp_q.push_back(pk(1,1,0,0,0,0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 3'b000, 1,0));
                4'b0010: exp_q.push_back(pk(0,0,0,0,0,1,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b01, 3'b000, 1,0));
                4'b0100: exp_q.push_back(pk(0,0,0,0,0,zero,0,0,0,0,0, 2'b10,2'b00,2'b00,2'b10, 3'b101, 1,0));
                4'b1000: begin
                    exp_q.push_back(pk(0,0,0,0,0,0,0,0,0,0,0, 2'b10,2'b00,2'b00,2'b00, calu, 0,0));
                    exp_q.push_back(pk(0,0,0,1,func[0],0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, calu, 1,0));
                end
                default: begin
                    exp_q.push_back(pk(0,0,0,0,0,0,0,0,0,0,0, 2'b10,2'b10,2'b00,2'b00, {1'b0, op[1:0]}, 0,0));
                    exp_q.push_back(pk(0,0,0,1,0,0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 3'b000, 1,0));
                end
            endcase
        end
    endtask

    task automatic step_check(input string name, input logic [23:0] exp);
        @(negedge clk);
        chk(name, {8'd0, obs}, {8'd0, exp});
        @(posedge clk); #1;
    endtask

    task automatic drain(input string name);
        while (exp_q.size() > 0) step_check(name, exp_q.pop_front());
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("reset_we_low", {8'd0, obs & WE_MASK}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    typedef struct {
        string      name;
        logic [3:0] op;
        logic [8:0] func;
        logic       zero;
        int         cycles;
        int         rw;
        int         mw;
        int         pcw;
        int         a3;
    } vec_t;
    vec_t tbl[$];

    initial begin
        int cyc, rw, mw, pcw, a3;
        bit done;
        logic [3:0] rop;
        logic [8:0] rfunc;

        tbl.push_back('{"load",    4'h0, 9'h000, 1'b0, 4, 1, 0, 1, 0});
        tbl.push_back('{"store",   4'h1, 9'h000, 1'b0, 3, 0, 1, 1, 0});
        tbl.push_back('{"jump",    4'h2, 9'h000, 1'b0, 3, 0, 0, 2, 0});
        tbl.push_back('{"brz_tkn", 4'h4, 9'h000, 1'b1, 3, 0, 0, 2, 0});
        tbl.push_back('{"brz_nt",  4'h4, 9'h000, 1'b0, 3, 0, 0, 1, 0});
        tbl.push_back('{"c_add",   4'h8, 9'h004, 1'b0, 4, 1, 0, 1, 0});
        tbl.push_back('{"c_moveto",4'h8, 9'h001, 1'b0, 4, 1, 0, 1, 1});
        tbl.push_back('{"c_nop",   4'h8, 9'h080, 1'b0, 2, 0, 0, 1, 0});
        tbl.push_back('{"addi",    4'hC, 9'h1FF, 1'b0, 4, 1, 0, 1, 0});
        tbl.push_back('{"ori",     4'hF, 9'h000, 1'b0, 4, 1, 0, 1, 0});
        if (!TRAP_EN) begin
            tbl.push_back('{"ill_op",   4'h3, 9'h000, 1'b0, 2, 0, 0, 1, 0});
            tbl.push_back('{"ill_f8",   4'h8, 9'h100, 1'b0, 2, 0, 0, 1, 0});
            tbl.push_back('{"ill_2hot", 4'h8, 9'h003, 1'b0, 2, 0, 0, 1, 0});
        end

        // Reset state, then the first cycle out of reset must be FETCH.
        do_reset();
        @(negedge clk);
        chk("reset_fetch", {8'd0, obs}, {8'd0, pk(0,0,1,0,0,1,1,0,0,0,0, 2'b00,2'b01,2'b00,2'b00, 3'b000, 0,0)});
        chk("reset_halted", {31'd0, halted}, 32'd0);
        @(posedge clk); #1;
        // That FETCH retired nothing yet; finish it as a NOP.
        Op = 4'h8; Func = 9'h080;
        step_check("nop_after_reset", pk(0,0,0,0,0,0,0,0,0,1,1, 2'b00,2'b00,2'b00,2'b00, 3'b000, 1,0));

        // Table: cycle count to instr_done and write-enable totals.
        foreach (tbl[i]) begin
            Op = tbl[i].op; Func = tbl[i].func; Zero = tbl[i].zero;
            cyc = 0; rw = 0; mw = 0; pcw = 0; a3 = 0; done = 1'b0;
            while (!done && cyc < 10) begin
                @(negedge clk);
                cyc++;
                rw += RegWrite; mw += MemWrite; pcw += PCWrite;
                if (RegWrite) a3 += A3Src;
                done = instr_done;
                @(posedge clk); #1;
            end
            chk({tbl[i].name, "_cycles"}, cyc, tbl[i].cycles);
            chk({tbl[i].name, "_regwrite"}, rw, tbl[i].rw);
            chk({tbl[i].name, "_memwrite"}, mw, tbl[i].mw);
            chk({tbl[i].name, "_pcwrite"}, pcw, tbl[i].pcw);
            chk({tbl[i].name, "_a3src"}, a3, tbl[i].a3);
        end

        // BRZ: PCWrite tracks Zero combinationally inside the BRZ state.
        Op = 4'h4; Func = 9'h000; Zero = 1'b0;
        model_instr(Op, Func, 1'b0);
        step_check("brz_fetch", exp_q.pop_front());
        step_check("brz_decode", exp_q.pop_front());
        exp_q.delete();
        #1; chk("brz_zero0_pcwrite", {31'd0, PCWrite}, 32'd0);
        Zero = 1'b1;
        #1; chk("brz_zero1_pcwrite", {31'd0, PCWrite}, 32'd1);
        @(posedge clk); #1;

        // Reset during MEMRD: no write, FETCH right after deassertion.
        Op = 4'h0; Zero = 1'b0;
        model_instr(Op, Func, Zero);
        step_check("ldr_fetch", exp_q.pop_front());
        step_check("ldr_decode", exp_q.pop_front());
        exp_q.delete();
        @(negedge clk);
        chk("ldr_memrd_adr", {31'd0, AdrSrc}, 32'd1);
        reset = 1'b1;
        #1; chk("ldr_reset_we", {8'd0, obs & WE_MASK}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        model_instr(Op, Func, Zero);
        drain("ldr_after_reset");

        // Illegal opcode.
        Op = 4'h3; Func = 9'h000;
        model_instr(Op, Func, Zero);
        drain("illegal_op");
        if (TRAP_EN) begin
            for (int k = 0; k < 3; k++) begin
                Op = 4'h1;
                step_check("halt_hold", pk(0,0,0,0,0,0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 3'b000, 0,1));
            end
            do_reset();
        end
        model_instr(4'h1, 9'h000, Zero);
        Op = 4'h1;
        drain("after_illegal");

        // Random instruction stream against the reference.
        for (int n = 0; n < 300; n++) begin
            do begin
                rop = 4'($urandom_range(0, 15));
                if ($urandom_range(0, 1) == 1) rfunc = 9'd1 << $urandom_range(0, 8);
                else rfunc = 9'($urandom);
            end while (TRAP_EN && !legal_instr(rop, rfunc));
            Op = rop; Func = rfunc; Zero = 1'($urandom);
            model_instr(Op, Func, Zero);
            drain("random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Moore-style control FSM that sequences the 16-bit multicycle accumulator datapath: fetch, decode, execute, memory and writeback. It decodes `Op`/`Func` from the instruction register and drives every mux select, write enable and ALU operation. It sits beside the datapath in the CPU top level. Its only datapath feedback is `Zero`.

## Interface
- `STATE_W`, default 4: width of the `state_dbg` output.
- `clk` in 1: clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `Op` in 4: `Instr[15:12]`.
- `Func` in 9: `Instr[8:0]`, one-hot C-type sub-op.
- `Zero` in 1: combinational ALU zero flag.
- `AdrSrc, MemWrite, IRWrite, RegWrite, A3Src, PCWrite, OldPCWrite, MDRWrite, ResultSrc, AWrite, BWrite` out 1 each: datapath controls.
- `ALUSrcA, ALUSrcB, ImmSrc, PCSrc` out 2 each: mux selects.
- `ALUControl` out 3: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 NOT In2, 101 pass In1, 110 pass In2.
- `instr_done` out 1: one-cycle pulse in the last state of each instruction.
- `halted` out 1: high in HALT.
- `state_dbg` out STATE_W: current state encoding.

## Operation
- Opcodes:
  - 0000 LOAD: R0 <- M[Imm12].
  - 0001 STORE: M[Imm12] <- R0.
  - 0010 JUMP.
  - 0100 BRZ: if R0==0, PC <- {OldPC[11:9], Imm9}.
  - 1000 C-type.
  - 1100 ADDI, 1101 SUBI, 1110 ANDI, 1111 ORI: R0 <- R0 op zext(Imm12), with ImmSrc=00.
- C-type `Func` bits:
  - bit0 MOVETO: Ri <- R0.
  - bit1 MOVEFROM: R0 <- Ri.
  - bit2 ADD, bit3 SUB, bit4 AND, bit5 OR.
  - bit6 NOT: R0 <- ~Ri.
  - bit7 NOP.
  - Any other `Func` value, and any unlisted `Op`, is illegal.
- Outputs are purely a function of state. Every output is 0 unless listed for that state.
- States:
  - FETCH: IRWrite, OldPCWrite, PCWrite, ALUSrcB=01, ALU ADD, PCSrc=00. Next: DECODE.
  - DECODE: AWrite, BWrite. Next by Op: MEMRD, MEMWR, JMP, BRZ, CEXEC or IEXEC. C-type NOP goes to FETCH with `instr_done`. Illegal goes to ILLEGAL handling.
  - MEMRD: AdrSrc, MDRWrite. Next: LDWB.
  - LDWB: ResultSrc=1, A3Src=0, RegWrite, `instr_done`. Next: FETCH.
  - MEMWR: AdrSrc, MemWrite (write data is register A = R0), `instr_done`. Next: FETCH.
  - JMP: PCSrc=01, PCWrite, `instr_done`. Next: FETCH.
  - BRZ: ALUSrcA=10, ALU pass In1, PCSrc=10, PCWrite=Zero (the only combinational-input-dependent output), `instr_done`. Next: FETCH.
  - CEXEC: ALUSrcA=10, ALUSrcB=00, ALUControl from Func (MOVETO 101, MOVEFROM 110, ADD 000, SUB 001, AND 010, OR 011, NOT 100). Next: CWB.
  - CWB: RegWrite, ResultSrc=0, A3Src=1 for MOVETO else 0, `instr_done`. Next: FETCH.
  - IEXEC: ALUSrcA=10, ALUSrcB=10, ImmSrc=00, ALUControl from Op[1:0] (00 ADD, 01 SUB, 10 AND, 11 OR). Next: IWB.
  - IWB: RegWrite, A3Src=0, ResultSrc=0, `instr_done`. Next: FETCH.
- Func and Op are sampled from the IR, which is stable after FETCH. In CWB the controller holds the CEXEC ALUControl.

## Timing
- Reset: state FETCH, `halted`=0. While `reset` is high, all write enables (MemWrite, IRWrite, RegWrite, PCWrite, OldPCWrite, MDRWrite, AWrite, BWrite) are forced to 0.
- Reset asserted mid-instruction: the instruction is abandoned at the next edge, with no write in the reset cycle. The first cycle after deassertion is FETCH.
- Cycles per instruction, FETCH through the last state:
  - NOP: 2.
  - STORE, JUMP, BRZ: 3.
  - LOAD, C-type, I-type: 4.
- The ALUOut register updates every cycle, so the writeback state always follows its execute state directly.
- `instr_done` is high exactly one cycle per retired instruction.

## Configuration
- `MC_ILLEGAL_TRAP_EN` defined: an illegal Op/Func in DECODE moves to HALT. HALT drives all outputs 0 and `halted`=1, and stays there until `reset`. No `instr_done` is issued.
- `MC_ILLEGAL_TRAP_EN` undefined: an illegal instruction is treated as NOP. DECODE goes to FETCH and pulses `instr_done`. HALT is not synthesized and `halted` is tied to 0.

## Test plan
- LOAD 0x0110 with M[110]=0x1234 -> states FETCH, DECODE, MEMRD, LDWB; R0=0x1234; `instr_done` pulses in cycle 4.
- R0=5, R3=7, C-type ADD (Func=0x004, Ri=3) -> R0=0x000C after 4 cycles; MOVETO to R2 -> R2=0x000C with A3Src=1.
- BRZ with R0=0, OldPC=0x2A0, Imm9=0x015 -> PC=0x215; same instruction with R0=1 -> PC unchanged (PC+1).
- STORE 0x0110 with R0=0xBEEF -> MemWrite high for exactly one cycle with AdrSrc=1; M[110]=0xBEEF; 3-cycle latency.
- Op=0011 -> with the macro: HALT, `halted`=1, no further writes; without it: 2-cycle NOP, then the next instruction is fetched.
- Reset asserted during MEMRD -> no RegWrite occurs, and state is FETCH one cycle after deassertion.
